// File: rtl/timer_pkg.sv
// Shared encodings for the cook-time controller: FSM states, BCD limits and
// the digit field positions inside the 16-bit MM:SS register.
package timer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ENTRY = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [3:0] BCD_MAX       = 4'd9;
  localparam logic [3:0] SEC_TENS_WRAP = 4'd5;

  localparam int SEC_ONES_LSB = 0;
  localparam int SEC_TENS_LSB = 4;
  localparam int MIN_ONES_LSB = 8;
  localparam int MIN_TENS_LSB = 12;

  function automatic logic is_bcd_digit(input logic [3:0] d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/cook_time_controller_if.sv
// Keypad-encoder / actuator signal bundle seen by the cook-time controller.
// The controller takes the slave view; the driving side takes the master view.
interface cook_time_controller_if;
  logic        load;
  logic [3:0]  digit;
  logic        pgt_1hz;
  logic        start;
  logic        stop;
  logic        door_closed;
  logic        enablen;
  logic [15:0] time_bcd;
  logic        mag_on;
  logic        done;

  modport master (
    output load, digit, pgt_1hz, start, stop, door_closed,
    input  enablen, time_bcd, mag_on, done
  );

  modport slave (
    input  load, digit, pgt_1hz, start, stop, door_closed,
    output enablen, time_bcd, mag_on, done
  );
endinterface

// File: rtl/mmss_down_counter.sv
// 4-digit BCD MM:SS register: shift-in of a new least-significant digit,
// one-second decrement with BCD borrow, clear, and zero / one-second flags.
module mmss_down_counter
  import timer_pkg::*;
(
  input  logic        clk,
  input  logic        clearn,
  input  logic        i_clr,
  input  logic        i_shift,
  input  logic [3:0]  i_digit,
  input  logic        i_dec,
  output logic [15:0] o_time_bcd,
  output logic        o_zero,
  output logic        o_one
);

  logic [15:0] r_time;
  logic [15:0] w_dec_time;
  logic [3:0]  w_so;
  logic [3:0]  w_st;
  logic [3:0]  w_mo;
  logic [3:0]  w_mt;

  assign w_so = r_time[SEC_ONES_LSB +: 4];
  assign w_st = r_time[SEC_TENS_LSB +: 4];
  assign w_mo = r_time[MIN_ONES_LSB +: 4];
  assign w_mt = r_time[MIN_TENS_LSB +: 4];

  // Seconds tens above 5 are legal entries and simply count down from where they are.
  always_comb begin
    w_dec_time = r_time;
    if (w_so != 4'd0) begin
      w_dec_time[SEC_ONES_LSB +: 4] = w_so - 4'd1;
    end else if (w_st != 4'd0) begin
      w_dec_time[SEC_TENS_LSB +: 4] = w_st - 4'd1;
      w_dec_time[SEC_ONES_LSB +: 4] = BCD_MAX;
    end else if (w_mo != 4'd0) begin
      w_dec_time[MIN_ONES_LSB +: 4] = w_mo - 4'd1;
      w_dec_time[SEC_TENS_LSB +: 4] = SEC_TENS_WRAP;
      w_dec_time[SEC_ONES_LSB +: 4] = BCD_MAX;
    end else if (w_mt != 4'd0) begin
      w_dec_time[MIN_TENS_LSB +: 4] = w_mt - 4'd1;
      w_dec_time[MIN_ONES_LSB +: 4] = BCD_MAX;
      w_dec_time[SEC_TENS_LSB +: 4] = SEC_TENS_WRAP;
      w_dec_time[SEC_ONES_LSB +: 4] = BCD_MAX;
    end else begin
      w_dec_time = r_time;
    end
  end

  // Time register; clear beats shift beats decrement.
  always_ff @(posedge clk) begin
    if (!clearn || i_clr) begin
      r_time <= 16'h0000;
    end else if (i_shift) begin
      r_time <= {r_time[11:0], i_digit};
    end else if (i_dec) begin
      r_time <= w_dec_time;
    end else begin
      r_time <= r_time;
    end
  end

  assign o_time_bcd = r_time;
  assign o_zero     = (r_time == 16'h0000);
  assign o_one      = (r_time == 16'h0001);

endmodule

// File: rtl/cook_time_controller.sv
// Microwave cook-time sequencer: gates the keypad encoder, accepts BCD digits,
// counts MM:SS down on the 1 Hz tick and drives the magnetron and done flag.
module cook_time_controller
  import timer_pkg::*;
#(
  parameter int LOAD_GUARD = 2,
  parameter int DONE_TICKS = 3
) (
  input  logic                   clk,
  input  logic                   clearn,
  cook_time_controller_if.slave  bus
);

  localparam int GW = $clog2(LOAD_GUARD + 1);
  localparam int DW = $clog2(DONE_TICKS + 1);
  localparam logic [GW-1:0] GUARD_LAST = GW'(LOAD_GUARD - 1);
  localparam logic [GW-1:0] GUARD_ONE  = GW'(1);
  localparam logic [DW-1:0] DONE_LAST  = DW'(DONE_TICKS - 1);
  localparam logic [DW-1:0] DONE_ONE   = DW'(1);

  logic          r_load_q;
  logic          r_pgt_q, r_pgt_d;
  logic          r_start_q, r_start_d;
  logic          r_stop_q, r_stop_d;
  logic          r_door_q;
  logic [GW-1:0] r_guard_cnt;
  logic          r_acc_done;
  logic [DW-1:0] r_done_cnt;
  state_t        r_state;
  logic          r_enablen, r_mag_on, r_done;

  state_t        w_next;
  logic [DW-1:0] w_done_cnt_nxt;
  logic          w_shift, w_dec, w_clr;
  logic          w_tick, w_start, w_stop, w_accept, w_key_ok;
  logic          w_zero, w_one;
  logic [15:0]   w_time;

  assign w_tick   = r_pgt_q & ~r_pgt_d;
  assign w_start  = r_start_q & ~r_start_d;
  assign w_stop   = r_stop_q & ~r_stop_d;
  assign w_accept = r_load_q & ~r_acc_done & (r_guard_cnt == GUARD_LAST);
  assign w_key_ok = w_accept & is_bcd_digit(bus.digit);

  // Input synchronisation and edge-detect history.
  always_ff @(posedge clk) begin
    if (!clearn) begin
      r_load_q  <= 1'b0;
      r_pgt_q   <= 1'b0;
      r_pgt_d   <= 1'b0;
      r_start_q <= 1'b0;
      r_start_d <= 1'b0;
      r_stop_q  <= 1'b0;
      r_stop_d  <= 1'b0;
      r_door_q  <= 1'b0;
    end else begin
      r_load_q  <= bus.load;
      r_pgt_q   <= bus.pgt_1hz;
      r_pgt_d   <= r_pgt_q;
      r_start_q <= bus.start;
      r_start_d <= r_start_q;
      r_stop_q  <= bus.stop;
      r_stop_d  <= r_stop_q;
      r_door_q  <= bus.door_closed;
    end
  end

  // Key guard: one accept per press, re-armed only when load drops.
  always_ff @(posedge clk) begin
    if (!clearn || !r_load_q) begin
      r_guard_cnt <= '0;
      r_acc_done  <= 1'b0;
    end else begin
      if (!r_acc_done && (r_guard_cnt != GUARD_LAST)) begin
        r_guard_cnt <= r_guard_cnt + GUARD_ONE;
      end else begin
        r_guard_cnt <= r_guard_cnt;
      end
      r_acc_done <= r_acc_done | w_accept;
    end
  end

  // Next state; branch order encodes stop > door open > start > tick > key.
  always_comb begin
    w_next         = r_state;
    w_done_cnt_nxt = r_done_cnt;
    w_shift        = 1'b0;
    w_dec          = 1'b0;
    w_clr          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_key_ok) begin
          w_shift = 1'b1;
          w_next  = ST_ENTRY;
        end else begin
          w_next  = ST_IDLE;
        end
      end
      ST_ENTRY: begin
        if (w_stop) begin
          w_clr  = 1'b1;
          w_next = ST_IDLE;
        end else if (w_start && !w_zero && r_door_q) begin
          w_next = ST_RUN;
        end else if (w_key_ok) begin
          w_shift = 1'b1;
        end else begin
          w_next = ST_ENTRY;
        end
      end
      ST_RUN: begin
        if (w_stop || !r_door_q) begin
          w_next = ST_PAUSE;
        end else if (w_tick) begin
          w_dec = 1'b1;
          if (w_one) begin
            w_next         = ST_DONE;
            w_done_cnt_nxt = '0;
          end else begin
            w_next = ST_RUN;
          end
        end else begin
          w_next = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (w_stop) begin
          w_clr  = 1'b1;
          w_next = ST_IDLE;
        end else if (w_start && !w_zero && r_door_q) begin
          w_next = ST_RUN;
        end else begin
          w_next = ST_PAUSE;
        end
      end
      ST_DONE: begin
        if (w_stop) begin
          w_clr  = 1'b1;
          w_next = ST_IDLE;
        end else if (w_tick) begin
          if (r_done_cnt == DONE_LAST) begin
            w_next = ST_IDLE;
          end else begin
            w_done_cnt_nxt = r_done_cnt + DONE_ONE;
          end
        end else begin
          w_next = ST_DONE;
        end
      end
      default: begin
        w_clr  = 1'b1;
        w_next = ST_IDLE;
      end
    endcase
  end

  // State, done-tick count and outputs all register off the next state.
  always_ff @(posedge clk) begin
    if (!clearn) begin
      r_state    <= ST_IDLE;
      r_done_cnt <= '0;
      r_enablen  <= 1'b0;
      r_mag_on   <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_done_cnt <= w_done_cnt_nxt;
      r_enablen  <= (w_next == ST_RUN) || (w_next == ST_PAUSE) || (w_next == ST_DONE);
      r_mag_on   <= (w_next == ST_RUN);
      r_done     <= (w_next == ST_DONE);
    end
  end

  mmss_down_counter u_mmss (
    .clk        (clk),
    .clearn     (clearn),
    .i_clr      (w_clr),
    .i_shift    (w_shift),
    .i_digit    (bus.digit),
    .i_dec      (w_dec),
    .o_time_bcd (w_time),
    .o_zero     (w_zero),
    .o_one      (w_one)
  );

  assign bus.time_bcd = w_time;
  assign bus.enablen  = r_enablen;
  assign bus.mag_on   = r_mag_on;
  assign bus.done     = r_done;

endmodule

// File: tb/tb_cook_time_controller.sv
// Scoreboard bench for cook_time_controller: a decimal-arithmetic oven model
// predicts the outputs after each transaction, a monitor pops and compares.
module tb_cook_time_controller;

  localparam int LOAD_GUARD = 2;
  localparam int DONE_TICKS = 3;
  localparam int M_IDLE = 0, M_ENTRY = 1, M_RUN = 2, M_PAUSE = 3, M_DONE = 4;

  logic clk = 1'b0;
  logic clearn;
  always #5 clk = ~clk;

  cook_time_controller_if bus();

  cook_time_controller #(.LOAD_GUARD(LOAD_GUARD), .DONE_TICKS(DONE_TICKS)) dut (
    .clk    (clk),
    .clearn (clearn),
    .bus    (bus)
  );

  typedef struct {
    logic [15:0] t;
    logic        en_n;
    logic        mag;
    logic        dn;
    int          id;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   op_id    = 0;

  // Oven model: cook time held as a plain 4-digit decimal number.
  int m_mode, m_val, m_done_left;
  bit m_door;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic void m_reset();
    m_mode = M_IDLE; m_val = 0; m_done_left = 0;
  endfunction

  function automatic void m_key(input int d);
    if ((m_mode == M_IDLE || m_mode == M_ENTRY) && d <= 9) begin
      m_val  = (m_val * 10 + d) % 10000;
      m_mode = M_ENTRY;
    end
  endfunction

  function automatic void m_start();
    if ((m_mode == M_ENTRY || m_mode == M_PAUSE) && m_val != 0 && m_door) m_mode = M_RUN;
  endfunction

  function automatic void m_stop();
    if (m_mode == M_RUN) m_mode = M_PAUSE;
    else if (m_mode != M_IDLE) begin m_mode = M_IDLE; m_val = 0; end
  endfunction

  function automatic void m_set_door(input bit v);
    m_door = v;
    if (!v && m_mode == M_RUN) m_mode = M_PAUSE;
  endfunction

  function automatic void m_tick();
    int mm, ss;
    if (m_mode == M_RUN) begin
      mm = m_val / 100; ss = m_val % 100;
      if (ss > 0) ss = ss - 1;
      else begin mm = mm - 1; ss = 59; end
      m_val = mm * 100 + ss;
      if (m_val == 0) begin m_mode = M_DONE; m_done_left = DONE_TICKS; end
    end else if (m_mode == M_DONE) begin
      m_done_left = m_done_left - 1;
      if (m_done_left == 0) m_mode = M_IDLE;
    end
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_now();
    exp_t e;
    e.t    = to_bcd(m_val);
    e.en_n = (m_mode == M_RUN || m_mode == M_PAUSE || m_mode == M_DONE);
    e.mag  = (m_mode == M_RUN);
    e.dn   = (m_mode == M_DONE);
    e.id   = op_id;
    op_id++;
    sb_q.push_back(e);
  endtask

  task automatic press_key(input logic [3:0] d, input int hold);
    bus.digit = d; bus.load = 1'b1;
    cyc(hold);
    bus.load = 1'b0;
    cyc(4);
    if (hold >= LOAD_GUARD) m_key(int'(d));
    expect_now();
  endtask

  task automatic push_start(input int w);
    bus.start = 1'b1; cyc(w); bus.start = 1'b0; cyc(4);
    m_start(); expect_now();
  endtask

  task automatic push_stop();
    bus.stop = 1'b1; cyc(1); bus.stop = 1'b0; cyc(4);
    m_stop(); expect_now();
  endtask

  task automatic start_and_stop();
    bus.start = 1'b1; bus.stop = 1'b1; cyc(1);
    bus.start = 1'b0; bus.stop = 1'b0; cyc(4);
    m_stop(); expect_now();
  endtask

  task automatic tick();
    bus.pgt_1hz = 1'b1; cyc(1); bus.pgt_1hz = 1'b0; cyc(4);
    m_tick(); expect_now();
  endtask

  task automatic set_door(input bit v);
    bus.door_closed = v; cyc(4);
    m_set_door(v); expect_now();
  endtask

  task automatic do_clear();
    clearn = 1'b0; cyc(1);
    m_reset(); expect_now();
    cyc(1); clearn = 1'b1; cyc(2);
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req, input int id);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s op=%0d actual=%h required=%h", nm, id, act, req);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("time_bcd", bus.time_bcd, e.t, e.id);
        chk("enablen", {15'd0, bus.enablen}, {15'd0, e.en_n}, e.id);
        chk("mag_on", {15'd0, bus.mag_on}, {15'd0, e.mag}, e.id);
        chk("done", {15'd0, bus.done}, {15'd0, e.dn}, e.id);
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int op;
    bus.load = 1'b0; bus.digit = 4'd0; bus.pgt_1hz = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.door_closed = 1'b1;
    m_door = 1'b1;
    m_reset();
    clearn = 1'b0;
    cyc(2);
    expect_now();
    clearn = 1'b1;
    cyc(2);

    // Entry 0123, long press, invalid digit, too-short press
    press_key(4'd1, 5); press_key(4'd2, 5); press_key(4'd3, 5);
    press_key(4'd7, 50);
    press_key(4'hA, 5);
    press_key(4'd8, 1);
    push_stop();
    push_start(1);

    // 0:03 countdown into DONE and back to IDLE
    press_key(4'd3, 3); push_start(2);
    repeat (3) tick();
    repeat (DONE_TICKS) tick();

    // Minute borrow and sec_tens above 5
    press_key(4'd1, 2); press_key(4'd0, 2); press_key(4'd0, 2);
    push_start(1); tick(); push_stop(); push_stop();
    press_key(4'd9, 2); press_key(4'd0, 2);
    push_start(1); tick();

    // Door, pause and resume
    set_door(1'b0); push_start(1); tick();
    set_door(1'b1); push_start(1); tick();
    push_stop(); push_stop();

    // Simultaneous start+stop in ENTRY, then reset mid-run
    press_key(4'd5, 3); start_and_stop();
    press_key(4'd2, 3); push_start(1); tick(); do_clear();

    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 19);
      if (op < 6) press_key(4'($urandom_range(0, 15)), $urandom_range(1, 6));
      else if (op < 9) push_start($urandom_range(1, 3));
      else if (op < 15) tick();
      else if (op < 17) push_stop();
      else if (op < 19) set_door(m_door ? ($urandom_range(0, 2) != 0) : 1'b1);
      else if ($urandom_range(0, 3) == 0) do_clear();
      else start_and_stop();
    end

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain pending=%0d required=0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
